control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit -- multi-cycle Moore control FSM for a small RV64-style datapath.
//
// Sequence: INIT -> FETCH -> DECODE -> EXEC -> PCUPD -> FETCH ... ; HALT is terminal.
// Decoded: ld, sd, addi, subi, add, sub, beq/bne/blt/bge/bltu/bgeu.
//
// Ports
//   clk                     sole clock, rising edge
//   reset                   synchronous, active-high; forces INIT and blanks every output
//   saida_IR[31:0]          instruction register contents from the datapath
//   BEQ..BGEU               datapath comparator flags for Ra vs Rb
//   we, we_ram              register-file / RAM write enables (EXEC only)
//   load_PC, load_IR        PC load (INIT, PCUPD) / IR load (FETCH)
//   decisor0                ALU B = imm (1) / Rb (0)
//   decisor1                ALU A = Ra (1) / Rb (0)
//   decisor2                writeback = RAM (1) / ALU (0)
//   decisor3                PC source = PC + somador_PC (1) / PCres (0)
//   somador_subtrator       ALU subtract (1) / add (0)
//   Ra, Rb, Rw              register addresses
//   entrada_mux_add_sub     sign-extended ALU immediate
//   somador_PC              PC increment (1, or taken-branch offset)
//   PCres                   absolute PC load value (always 0, used by INIT)
//   halt                    stopped flag
//   retired[31:0]           retired-instruction count, wraps
//
// Build option
//   CU_ILLEGAL_HALT_EN      when defined, an unrecognised encoding in DECODE enters HALT
//                           (halt=1, no enables until reset). When undefined, it runs as a
//                           NOP (no writes, PC+1, counted as retired) and halt is tied 0.

module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] saida_IR,
    input  logic        BEQ,
    input  logic        BNE,
    input  logic        BLT,
    input  logic        BGE,
    input  logic        BLTU,
    input  logic        BGEU,
    output logic        we,
    output logic        we_ram,
    output logic        load_PC,
    output logic        load_IR,
    output logic        decisor0,
    output logic        decisor1,
    output logic        decisor2,
    output logic        decisor3,
    output logic        somador_subtrator,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic [4:0]  Rw,
    output logic [63:0] entrada_mux_add_sub,
    output logic [63:0] somador_PC,
    output logic [63:0] PCres,
    output logic        halt,
    output logic [31:0] retired
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [2:0] {
        StInit,
        StFetch,
        StDecode,
        StExec,
        StPcUpd,
        StHalt
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        br_taken_q, br_taken_d;
    logic [63:0] br_off_q, br_off_d;

    // ------------------------------------------------------------------
    // Instruction field extraction and classification
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm_i, imm_s, br_off;

    assign opcode = saida_IR[6:0];
    assign funct3 = saida_IR[14:12];
    assign funct7 = saida_IR[31:25];
    assign rs1    = saida_IR[19:15];
    assign rs2    = saida_IR[24:20];
    assign rd     = saida_IR[11:7];
    assign imm_i  = {{52{saida_IR[31]}}, saida_IR[31:20]};
    assign imm_s  = {{52{saida_IR[31]}}, saida_IR[31:25], saida_IR[11:7]};
    assign br_off = {{57{saida_IR[31]}}, saida_IR[31:25]};

    logic is_ld, is_sd, is_addi, is_subi, is_add, is_sub, is_branch;

    assign is_ld     = (opcode == OpLoad)  && (funct3 == 3'b011);
    assign is_sd     = (opcode == OpStore) && (funct3 == 3'b011);
    assign is_addi   = (opcode == OpImm)   && (funct3 == 3'b000);
    assign is_subi   = (opcode == OpImm)   && (funct3 == 3'b010);
    assign is_add    = (opcode == OpReg) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub    = (opcode == OpReg) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    // funct3 010/011 are not branch encodings
    assign is_branch = (opcode == OpBranch) && (funct3[2:1] != 2'b01);

`ifdef CU_ILLEGAL_HALT_EN
    logic legal;
    assign legal = is_ld | is_sd | is_addi | is_subi | is_add | is_sub | is_branch;
`endif

    // Branch condition selected by funct3
    logic br_cond;
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = BEQ;
            3'b001:  br_cond = BNE;
            3'b100:  br_cond = BLT;
            3'b101:  br_cond = BGE;
            3'b110:  br_cond = BLTU;
            3'b111:  br_cond = BGEU;
            default: br_cond = 1'b0;
        endcase
    end

    // Decoded datapath controls; an unrecognised encoding leaves them all 0
    logic [4:0]  dec_ra, dec_rb, dec_rw;
    logic [63:0] dec_imm;
    logic        dec_d0, dec_d1, dec_d2, dec_sub, dec_we;

    always_comb begin
        dec_ra  = '0;
        dec_rb  = '0;
        dec_rw  = '0;
        dec_imm = '0;
        dec_d0  = 1'b0;
        dec_d1  = 1'b0;
        dec_d2  = 1'b0;
        dec_sub = 1'b0;
        dec_we  = 1'b0;
        if (is_ld || is_addi || is_subi) begin
            dec_ra  = rs1;
            dec_rw  = rd;
            dec_imm = imm_i;
            dec_d0  = 1'b1;
            dec_d1  = 1'b1;
            dec_d2  = is_ld;
            dec_sub = is_subi;
            dec_we  = (rd != 5'd0);
        end else if (is_add || is_sub) begin
            dec_ra  = rs1;
            dec_rb  = rs2;
            dec_rw  = rd;
            dec_d1  = 1'b1;
            dec_sub = is_sub;
            dec_we  = (rd != 5'd0);
        end else if (is_sd) begin
            // store data travels on the A side, base on the B side
            dec_ra  = rs2;
            dec_rb  = rs1;
            dec_imm = imm_s;
            dec_d0  = 1'b1;
            dec_d2  = 1'b1;
        end else if (is_branch) begin
            dec_ra  = rs1;
            dec_rb  = rs2;
            dec_d1  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            retired_q  <= '0;
            br_taken_q <= 1'b0;
            br_off_q   <= '0;
        end else begin
            state_q    <= state_d;
            retired_q  <= retired_d;
            br_taken_q <= br_taken_d;
            br_off_q   <= br_off_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        retired_d  = retired_q;
        br_taken_d = br_taken_q;
        br_off_d   = br_off_q;
        case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
`ifdef CU_ILLEGAL_HALT_EN
                state_d = legal ? StExec : StHalt;
`else
                state_d = StExec;
`endif
            end
            StExec: begin
                state_d    = StPcUpd;
                // count on entry to PCUPD so the new total is visible there
                retired_d  = retired_q + 32'd1;
                br_taken_d = is_branch & br_cond;
                br_off_d   = br_off;
            end
            StPcUpd:  state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StInit;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs; everything is blanked while reset is high
    // ------------------------------------------------------------------
    always_comb begin
        we                  = 1'b0;
        we_ram              = 1'b0;
        load_PC             = 1'b0;
        load_IR             = 1'b0;
        decisor0            = 1'b0;
        decisor1            = 1'b0;
        decisor2            = 1'b0;
        decisor3            = 1'b0;
        somador_subtrator   = 1'b0;
        Ra                  = '0;
        Rb                  = '0;
        Rw                  = '0;
        entrada_mux_add_sub = '0;
        somador_PC          = '0;
        PCres               = '0;
        if (!reset) begin
            case (state_q)
                StInit: begin
                    // PC <= PCres (0)
                    load_PC = 1'b1;
                end
                StFetch: begin
                    load_IR = 1'b1;
                end
                StDecode, StExec: begin
                    // Operand selects stay up through EXEC so the datapath
                    // computes and writes back with the same addresses.
                    Ra                  = dec_ra;
                    Rb                  = dec_rb;
                    Rw                  = dec_rw;
                    entrada_mux_add_sub = dec_imm;
                    decisor0            = dec_d0;
                    decisor1            = dec_d1;
                    decisor2            = dec_d2;
                    somador_subtrator   = dec_sub;
                    if (state_q == StExec) begin
                        we     = dec_we;
                        we_ram = is_sd;
                    end
                end
                StPcUpd: begin
                    load_PC    = 1'b1;
                    decisor3   = 1'b1;
                    // taken offset 0 reloads the same PC
                    somador_PC = br_taken_q ? br_off_q : 64'd1;
                end
                default: ;
            endcase
        end
    end

    assign retired = reset ? 32'd0 : retired_q;

`ifdef CU_ILLEGAL_HALT_EN
    assign halt = !reset && (state_q == StHalt);
`else
    assign halt = 1'b0;
`endif

endmodule
